// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR stream checker: self-seeds from received words, locks, then counts mismatches.
// Optional first-mismatch capture is built when LFSR_CHK_FIRST_ERR_EN is defined.
module lfsr_seq_checker #(
    parameter int unsigned        N_BITS   = 8,
    parameter logic [N_BITS-1:0]  TAPS     = 8'h1D,
    parameter int unsigned        CNT_W    = 16,
    parameter int unsigned        SYNC_LEN = 2,
    parameter int unsigned        LOSS_TH  = 4
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [N_BITS-1:0] data_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [N_BITS-1:0] expected_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic [N_BITS-1:0] first_err_data_o,
    output logic [N_BITS-1:0] first_err_exp_o
);

    localparam int unsigned HIT_W  = $clog2(SYNC_LEN + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_TH + 1);
    localparam logic [HIT_W-1:0]  HitMax  = HIT_W'(SYNC_LEN);
    localparam logic [MISS_W-1:0] MissMax = MISS_W'(LOSS_TH);

    typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

    state_e             state_q, state_d;
    logic [N_BITS-1:0]  pred_q, pred_d;
    logic               seeded_q, seeded_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               mismatch;

    function automatic logic [N_BITS-1:0] step(input logic [N_BITS-1:0] x);
        return {^(x & TAPS), x[N_BITS-1:1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign mismatch = (data_i != pred_q);

`ifdef LFSR_CHK_FIRST_ERR_EN
    logic               first_cap;
    logic [N_BITS-1:0]  first_data_q, first_exp_q;
`endif

    always_comb begin
        state_d    = state_q;
        pred_d     = pred_q;
        seeded_d   = seeded_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
`ifdef LFSR_CHK_FIRST_ERR_EN
        first_cap  = 1'b0;
`endif
        if (clear_i) begin
            state_d    = StIdle;
            seeded_d   = 1'b0;
            hit_d      = '0;
            miss_d     = '0;
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (!en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StSync;
                    hit_d    = '0;
                    seeded_d = 1'b0;
                end
                StSync: begin
                    if (valid_i) begin
                        if (!seeded_q) begin
                            // All-zero is the LFSR lockup state, never a usable seed.
                            if (data_i != '0) begin
                                pred_d   = step(data_i);
                                seeded_d = 1'b1;
                            end
                        end else if (!mismatch) begin
                            pred_d = step(pred_q);
                            if (hit_q + 1'b1 == HitMax) begin
                                state_d = StLocked;
                                hit_d   = '0;
                                miss_d  = '0;
                            end else begin
                                hit_d = hit_q + 1'b1;
                            end
                        end else begin
                            hit_d = '0;
                            if (data_i == '0) begin
                                seeded_d = 1'b0;
                            end else begin
                                pred_d = step(data_i);
                            end
                        end
                    end
                end
                StLocked: begin
                    if (valid_i) begin
                        // Flywheel: prediction advances whether or not the word matched.
                        pred_d     = step(pred_q);
                        word_cnt_d = sat_inc(word_cnt_q);
                        if (mismatch) begin
                            err_d     = 1'b1;
                            err_cnt_d = sat_inc(err_cnt_q);
`ifdef LFSR_CHK_FIRST_ERR_EN
                            first_cap = (err_cnt_q == '0);
`endif
                            if (miss_q + 1'b1 == MissMax) begin
                                state_d  = StSync;
                                hit_d    = '0;
                                seeded_d = 1'b0;
                                miss_d   = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pred_q     <= '0;
            seeded_q   <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            seeded_q   <= seeded_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

`ifdef LFSR_CHK_FIRST_ERR_EN
    // Capture is keyed off the error counter being zero, which only clear/reset restore.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            first_data_q <= '0;
            first_exp_q  <= '0;
        end else if (clear_i) begin
            first_data_q <= '0;
            first_exp_q  <= '0;
        end else if (first_cap) begin
            first_data_q <= data_i;
            first_exp_q  <= pred_q;
        end
    end

    assign first_err_data_o = first_data_q;
    assign first_err_exp_o  = first_exp_q;
`else
    assign first_err_data_o = '0;
    assign first_err_exp_o  = '0;
`endif

    assign locked_o   = (state_q == StLocked);
    assign err_o      = err_q;
    assign expected_o = pred_q;
    assign err_cnt_o  = err_cnt_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed test-plan sequences plus randomized streams checked
// against a chain-based reference model; two DUTs (CNT_W 16 and 4) share the stimulus.
module tb_lfsr_seq_checker;

    localparam int SyncLen = 2;
    localparam int LossTh  = 4;
`ifdef LFSR_CHK_FIRST_ERR_EN
    localparam bit FirstEn = 1'b1;
`else
    localparam bit FirstEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        en_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i = 8'h00;

    logic        locked_a, err_a, locked_b, err_b;
    logic [7:0]  exp_a, fd_a, fe_a, exp_b, fd_b, fe_b;
    logic [15:0] ec_a, wc_a;
    logic [3:0]  ec_b, wc_b;

    lfsr_seq_checker #(.N_BITS(8), .TAPS(8'h1D), .CNT_W(16), .SYNC_LEN(SyncLen),
                       .LOSS_TH(LossTh)) dut (
        .clk(clk), .rst_ni(rst_ni), .clear_i(clear_i), .en_i(en_i), .valid_i(valid_i),
        .data_i(data_i), .locked_o(locked_a), .err_o(err_a), .expected_o(exp_a),
        .err_cnt_o(ec_a), .word_cnt_o(wc_a), .first_err_data_o(fd_a), .first_err_exp_o(fe_a)
    );

    lfsr_seq_checker #(.N_BITS(8), .TAPS(8'h1D), .CNT_W(4), .SYNC_LEN(SyncLen),
                       .LOSS_TH(LossTh)) dut4 (
        .clk(clk), .rst_ni(rst_ni), .clear_i(clear_i), .en_i(en_i), .valid_i(valid_i),
        .data_i(data_i), .locked_o(locked_b), .err_o(err_b), .expected_o(exp_b),
        .err_cnt_o(ec_b), .word_cnt_o(wc_b), .first_err_data_o(fd_b), .first_err_exp_o(fe_b)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: sync is tracked as a chain of words each equal to step(previous word).
    typedef enum int {MIdle, MSync, MLocked} mmode_e;
    mmode_e     m_mode;
    bit         m_have_last, m_have_first, m_err;
    int         m_chain, m_miss, m_ec, m_wc;
    logic [7:0] m_last, m_pred, m_fd, m_fe;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        int fb;
        fb = $countones(x & 8'h1D) % 2;
        return 8'((fb << 7) | (x >> 1));
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic model_reset();
        m_mode = MIdle; m_have_last = 0; m_have_first = 0; m_err = 0;
        m_chain = 0; m_miss = 0; m_ec = 0; m_wc = 0;
        m_last = 0; m_pred = 0; m_fd = 0; m_fe = 0;
    endtask

    task automatic model_tick();
        m_err = 0;
        if (clear_i) begin
            m_mode = MIdle; m_ec = 0; m_wc = 0; m_have_first = 0; m_fd = 0; m_fe = 0;
            m_have_last = 0; m_chain = 0; m_miss = 0;
        end else if (!en_i) begin
            m_mode = MIdle;
        end else if (m_mode == MIdle) begin
            m_mode = MSync; m_have_last = 0; m_chain = 0;
        end else if (m_mode == MSync) begin
            if (valid_i) begin
                if (m_have_last && data_i == nxt(m_last)) m_chain++;
                else m_chain = 0;
                if (data_i != 8'h00) begin
                    m_have_last = 1; m_last = data_i; m_pred = nxt(data_i);
                end else begin
                    m_have_last = 0;
                end
                if (m_chain == SyncLen) begin
                    m_mode = MLocked; m_miss = 0;
                end
            end
        end else if (valid_i) begin
            m_wc++;
            if (data_i != m_pred) begin
                m_err = 1; m_ec++; m_miss++;
                if (FirstEn && !m_have_first) begin
                    m_have_first = 1; m_fd = data_i; m_fe = m_pred;
                end
                if (m_miss == LossTh) begin
                    m_mode = MSync; m_have_last = 0; m_chain = 0; m_miss = 0;
                end
            end else begin
                m_miss = 0;
            end
            m_pred = nxt(m_pred);
        end
    endtask

    task automatic check_all();
        chk("locked",   32'(locked_a), 32'(m_mode == MLocked));
        chk("err",      32'(err_a),    32'(m_err));
        chk("expected", 32'(exp_a),    32'(m_pred));
        chk("err_cnt",  32'(ec_a),     32'(sat(m_ec, 16)));
        chk("word_cnt", 32'(wc_a),     32'(sat(m_wc, 16)));
        chk("first_d",  32'(fd_a),     32'(m_fd));
        chk("first_e",  32'(fe_a),     32'(m_fe));
        chk("locked4",  32'(locked_b), 32'(m_mode == MLocked));
        chk("err4",     32'(err_b),    32'(m_err));
        chk("err_cnt4", 32'(ec_b),     32'(sat(m_ec, 4)));
        chk("wrd_cnt4", 32'(wc_b),     32'(sat(m_wc, 4)));
    endtask

    task automatic tick(input bit v, input logic [7:0] d);
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        #1;
        model_tick();
        check_all();
    endtask

    logic [7:0] g;

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_ni = 1'b1;

        // Lock on 01,80,40; then 20,10,88 counted in LOCKED.
        en_i = 1'b1;
        tick(0, 8'h00);
        tick(1, 8'h01);
        tick(1, 8'h80);
        chk("lock_early", 32'(locked_a), 32'd0);
        tick(1, 8'h40);
        chk("lock_rise", 32'(locked_a), 32'd1);
        tick(1, 8'h20);
        tick(1, 8'h10);
        tick(1, 8'h88);
        chk("lock_wcnt", 32'(wc_a), 32'd3);
        chk("lock_ecnt", 32'(ec_a), 32'd0);

        // Single error: C5 instead of C4, then E2 matches.
        tick(1, 8'hC5);
        chk("single_err", 32'(err_a), 32'd1);
        chk("single_ecnt", 32'(ec_a), 32'd1);
        chk("first_data", 32'(fd_a), FirstEn ? 32'hC5 : 32'h00);
        chk("first_exp", 32'(fe_a), FirstEn ? 32'hC4 : 32'h00);
        tick(1, 8'hE2);
        chk("single_pulse", 32'(err_a), 32'd0);
        chk("single_hold", 32'(locked_a), 32'd1);

        // Lock loss: four consecutive 0x55.
        for (int i = 0; i < 4; i++) tick(1, 8'h55);
        chk("loss_ecnt", 32'(ec_a), 32'd5);
        chk("loss_lock", 32'(locked_a), 32'd0);

        // Zero seed ignored, lock on 40.
        tick(1, 8'h00);
        tick(1, 8'h01);
        tick(1, 8'h80);
        chk("zseed_early", 32'(locked_a), 32'd0);
        tick(1, 8'h40);
        chk("zseed_lock", 32'(locked_a), 32'd1);

        // Saturation: 20 interleaved mismatches keep lock.
        g = 8'h20;
        for (int i = 0; i < 20; i++) begin
            tick(1, g ^ 8'h01);
            g = nxt(g);
            tick(1, g);
            g = nxt(g);
        end
        chk("sat_ecnt4", 32'(ec_b), 32'd15);
        chk("sat_ecnt16", 32'(ec_a), 32'd25);
        chk("sat_lock", 32'(locked_b), 32'd1);

        // Clear with a valid word in the same cycle.
        clear_i = 1'b1;
        tick(1, g);
        clear_i = 1'b0;
        chk("clr_ecnt", 32'(ec_b), 32'd0);
        chk("clr_lock", 32'(locked_a), 32'd0);

        // Relock, then async reset mid-cycle.
        tick(0, 8'h00);
        tick(1, 8'h01);
        tick(1, 8'h80);
        tick(1, 8'h40);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_lock", 32'(locked_a), 32'd0);
        #1;
        rst_ni = 1'b1;
        g = 8'h20;
        for (int i = 0; i < 8; i++) begin
            tick(1, g);
            g = nxt(g);
        end

        // Randomized stream with errors, gaps, zero words, enable drops and clears.
        g = 8'h01;
        for (int i = 0; i < 4000; i++) begin
            int r;
            bit v;
            logic [7:0] w;
            r = int'($urandom_range(0, 999));
            en_i    = (r >= 5);
            clear_i = (r >= 5 && r < 8);
            v = ($urandom_range(0, 3) != 0);
            w = g;
            if ($urandom_range(0, 19) == 0) w = 8'($urandom);
            if ($urandom_range(0, 99) == 0) w = 8'h00;
            if ((i % 700) >= 690) w = 8'($urandom);
            tick(v, w);
            if (v) g = nxt(g);
        end
        clear_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
